// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter: default widths, response-owner
// encoding and the starve counter width helper.
package sram_arb_pkg;

   localparam int unsigned ADDR_W_DEF     = 32;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned STARVE_MAX_DEF = 3;

   // Legacy owner encodings, kept as plain constants for older code that
   // compares against raw values.
   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_INST = 2'd1;
   localparam logic [1:0] RESP_DATA = 2'd2;

   typedef enum logic [1:0] {
      OWNER_NONE = RESP_NONE,
      OWNER_INST = RESP_INST,
      OWNER_DATA = RESP_DATA
   } resp_owner_t;

   // Starve counter must hold STARVE_MAX and is never narrower than 2 bits.
   function automatic int unsigned starve_w(input int unsigned max_cnt);
      int unsigned w;
      w = $clog2(max_cnt + 1);
      return (w < 2) ? 2 : w;
   endfunction

endpackage

// File: rtl/sram_arb_prio.sv
// Winner selection between the inst and data requesters. Data normally
// wins; inst is forced through once it has been denied STARVE_MAX times in
// a row.
module sram_arb_prio
   import sram_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic resetn,
   input  logic inst_req,
   input  logic data_req,
   output logic grant_inst,
   output logic grant_data
);

   localparam int unsigned CNT_W = starve_w(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;
   logic             starved;

   // Combinational grant: at most one winner per cycle.
   always_comb begin
      starved    = (starve_cnt == CNT_W'(STARVE_MAX));
      grant_inst = inst_req & (~data_req | starved);
      grant_data = data_req & ~grant_inst;
   end

   // Count consecutive inst denials, clear on an inst grant, saturate at STARVE_MAX.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         starve_cnt <= '0;
      else if (grant_inst)
         starve_cnt <= '0;
      else if (inst_req && !starved)
         starve_cnt <= starve_cnt + CNT_W'(1);
   end

endmodule

// File: rtl/sram_arb.sv
// Arbiter sharing one single-port SRAM between the fetch (inst) and memory
// (data) stages. One access per cycle; the response comes back the cycle
// after the grant to whichever master owned that access.
module sram_arb
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                clk,
   input  logic                resetn,

   input  logic                inst_req,
   input  logic [DATA_W/8-1:0] inst_we,
   input  logic [ADDR_W-1:0]   inst_addr,
   input  logic [DATA_W-1:0]   inst_wdata,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,

   input  logic                data_req,
   input  logic [DATA_W/8-1:0] data_we,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,

   output logic                sram_en,
   output logic [DATA_W/8-1:0] sram_we,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_wdata,
   input  logic [DATA_W-1:0]   sram_rdata
);

   logic        grant_inst;
   logic        grant_data;
   resp_owner_t resp_owner;
   resp_owner_t owner_nxt;
   logic        resp_rd;
   logic        rd_nxt;

   sram_arb_prio #(
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .clk        (clk),
      .resetn     (resetn),
      .inst_req   (inst_req),
      .data_req   (data_req),
      .grant_inst (grant_inst),
      .grant_data (grant_data)
   );

   // Route the winner's request to the SRAM; everything is gated while in
   // reset so no access or handshake leaks out during the reset window.
   always_comb begin
      inst_addr_ok = grant_inst & resetn;
      data_addr_ok = grant_data & resetn;
      sram_en      = (grant_inst | grant_data) & resetn;
      sram_we      = '0;
      if (sram_en)
         sram_we = grant_inst ? inst_we : data_we;
      sram_addr  = grant_inst ? inst_addr  : data_addr;
      sram_wdata = grant_inst ? inst_wdata : data_wdata;
   end

   // Next response owner and whether the granted access is a read.
   always_comb begin
      owner_nxt = OWNER_NONE;
      if (grant_inst)
         owner_nxt = OWNER_INST;
      else if (grant_data)
         owner_nxt = OWNER_DATA;
      rd_nxt = grant_inst ? ~|inst_we : ~|data_we;
   end

   // Response owner register; reset drops any pending response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_owner <= OWNER_NONE;
         resp_rd    <= 1'b0;
      end else begin
         resp_owner <= owner_nxt;
         resp_rd    <= rd_nxt;
      end
   end

   // Deliver the one-cycle response to the owner; read data only for reads.
   always_comb begin
      inst_data_ok = (resp_owner == OWNER_INST);
      data_data_ok = (resp_owner == OWNER_DATA);
      inst_rdata   = (inst_data_ok && resp_rd) ? sram_rdata : '0;
      data_rdata   = (data_data_ok && resp_rd) ? sram_rdata : '0;
   end

endmodule

// File: tb/tb_sram_arb.sv
// Randomized and directed bench for sram_arb against a transaction-level
// reference model (rules for priority/starvation plus a reference memory).
module tb_sram_arb;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int WW   = DW / 8;
   localparam int SMAX = 3;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          inst_req = 1'b0, data_req = 1'b0;
   logic [WW-1:0] inst_we = '0, data_we = '0;
   logic [AW-1:0] inst_addr = '0, data_addr = '0;
   logic [DW-1:0] inst_wdata = '0, data_wdata = '0;
   logic          inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok;
   logic [DW-1:0] inst_rdata, data_rdata;
   logic          sram_en;
   logic [WW-1:0] sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_arb #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_we      (inst_we),
      .inst_addr    (inst_addr),
      .inst_wdata   (inst_wdata),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .data_req     (data_req),
      .data_we      (data_we),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .sram_en      (sram_en),
      .sram_we      (sram_we),
      .sram_addr    (sram_addr),
      .sram_wdata   (sram_wdata),
      .sram_rdata   (sram_rdata)
   );

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [WW-1:0] we);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < WW; b++)
         if (we[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // SRAM environment: single port, read data one cycle after enabled read.
   logic [DW-1:0] sram_mem [bit [AW-1:0]];
   always @(posedge clk) begin
      if (sram_en) begin
         if (sram_we != '0)
            sram_mem[sram_addr] = merge(sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : '0,
                                        sram_wdata, sram_we);
         else
            sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : '0;
      end
   end

   // Reference model state.
   logic [DW-1:0] ref_mem [bit [AW-1:0]];
   int            m_starve = 0;
   int            m_owner  = 0;   // 0 none, 1 inst, 2 data
   logic [DW-1:0] m_rdata  = '0;

   // Observations captured by the last step for directed checks.
   logic          obs_gi;
   logic [DW-1:0] obs_ird, obs_drd;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One bus cycle: drive, check against the model, advance the model.
   task automatic step(input bit ir, input logic [WW-1:0] iwe, input logic [AW-1:0] ia,
                       input logic [DW-1:0] iwd, input bit dr, input logic [WW-1:0] dwe,
                       input logic [AW-1:0] da, input logic [DW-1:0] dwd);
      bit            eg_i, eg_d;
      logic [WW-1:0] g_we;
      logic [AW-1:0] g_a;
      logic [DW-1:0] g_wd;
      @(negedge clk);
      inst_req = ir; inst_we = iwe; inst_addr = ia; inst_wdata = iwd;
      data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
      #2;
      eg_i = 0; eg_d = 0;
      if (ir && dr) begin
         if (m_starve == SMAX) eg_i = 1; else eg_d = 1;
      end else begin
         eg_i = ir; eg_d = dr;
      end
      g_we = eg_i ? iwe : dwe;
      g_a  = eg_i ? ia  : da;
      g_wd = eg_i ? iwd : dwd;
      chk("inst_addr_ok", inst_addr_ok, eg_i);
      chk("data_addr_ok", data_addr_ok, eg_d);
      chk("sram_en", sram_en, eg_i | eg_d);
      chk("sram_we", sram_we, (eg_i | eg_d) ? g_we : '0);
      if (eg_i | eg_d) begin
         chk("sram_addr", sram_addr, g_a);
         chk("sram_wdata", sram_wdata, g_wd);
      end
      chk("inst_data_ok", inst_data_ok, m_owner == 1);
      chk("data_data_ok", data_data_ok, m_owner == 2);
      chk("inst_rdata", inst_rdata, (m_owner == 1) ? m_rdata : '0);
      chk("data_rdata", data_rdata, (m_owner == 2) ? m_rdata : '0);
      obs_gi = inst_addr_ok; obs_ird = inst_rdata; obs_drd = data_rdata;
      if (eg_i) m_starve = 0;
      else if (ir && m_starve < SMAX) m_starve++;
      if (eg_i | eg_d) begin
         m_owner = eg_i ? 1 : 2;
         if (g_we != '0) begin
            ref_mem[g_a] = merge(ref_mem.exists(g_a) ? ref_mem[g_a] : '0, g_wd, g_we);
            m_rdata = '0;
         end else
            m_rdata = ref_mem.exists(g_a) ? ref_mem[g_a] : '0;
      end else
         m_owner = 0;
      @(posedge clk);
   endtask

   task automatic idle();
      step(0, '0, '0, '0, 0, '0, '0, '0);
   endtask

   // All handshake/enable/data outputs must be zero while in reset.
   task automatic check_reset_outputs(input string tag);
      chk({tag, "_iaok"}, inst_addr_ok, 0);
      chk({tag, "_daok"}, data_addr_ok, 0);
      chk({tag, "_idok"}, inst_data_ok, 0);
      chk({tag, "_ddok"}, data_data_ok, 0);
      chk({tag, "_en"}, sram_en, 0);
      chk({tag, "_we"}, sram_we, 0);
      chk({tag, "_ird"}, inst_rdata, 0);
      chk({tag, "_drd"}, data_rdata, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] pat;
      // Reset with requests asserted.
      inst_req = 1; data_req = 1; inst_we = '1; data_we = '1;
      #13;
      check_reset_outputs("reset");
      inst_req = 0; data_req = 0; inst_we = '0; data_we = '0;
      @(posedge clk); #1 resetn = 1;

      // Single inst read.
      sram_mem[32'h1C00_0000] = 32'h0280_0C05;
      ref_mem[32'h1C00_0000]  = 32'h0280_0C05;
      step(1, '0, 32'h1C00_0000, '0, 0, '0, '0, '0);
      chk("r036_aok", obs_gi, 1);
      idle();
      chk("r036_rdata", obs_ird, 32'h0280_0C05);

      // Both requesting for 5 cycles: D,D,D,I,D.
      pat = '0;
      for (int c = 0; c < 5; c++) begin
         step(1, '0, 32'h40, '0, 1, '0, 32'h44, '0);
         pat = {pat[3:0], obs_gi};
      end
      chk("r037_seq", pat, 5'b00010);
      idle();

      // Data write then read back.
      step(0, '0, '0, '0, 1, 4'hF, 32'h100, 32'hDEAD_BEEF);
      step(0, '0, '0, '0, 1, '0, 32'h100, '0);
      idle();
      chk("r038_rdata", obs_drd, 32'hDEAD_BEEF);

      // Alternating masters.
      step(1, '0, 32'h100, '0, 0, '0, '0, '0);
      step(0, '0, '0, '0, 1, '0, 32'h1C00_0000, '0);
      idle();

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? WW'($urandom) : '0,
              AW'($urandom_range(0, 7) * 4), $urandom,
              $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? WW'($urandom) : '0,
              AW'($urandom_range(0, 7) * 4), $urandom);
      end
      idle();

      // Reset during a pending inst response.
      step(1, '0, 32'h1C00_0000, '0, 0, '0, '0, '0);
      #1 resetn = 0;
      inst_req = 1; data_req = 1; inst_we = '0; data_we = 4'hF;
      #1;
      check_reset_outputs("r040a");
      m_owner = 0; m_starve = 0;
      repeat (2) @(posedge clk);
      #3;
      check_reset_outputs("r040b");
      inst_req = 0; data_req = 0; data_we = '0;
      @(posedge clk); #1 resetn = 1;
      step(1, '0, 32'h1C00_0000, '0, 0, '0, '0, '0);
      chk("r040_grant", obs_gi, 1);
      idle();
      chk("r040_rdata", obs_ird, 32'h0280_0C05);
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
